// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit scheduler.
// Holds the transmitter state codes, the word width and the scheduler FSM state enum.
package uart_pkg;

    localparam int UART_WORD_W = 9;

    localparam logic [3:0] IDLE_S  = 4'h0;
    localparam logic [3:0] START_S = 4'h1;
    localparam logic [3:0] STOP_S  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin search: first eligible requester at or after ptr, wrapping upward.
// Produces a one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grant_any && eligible[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_CLIENTS requesters.
// Optional watchdog abort is compiled in with UART_TX_SCHED_WDOG_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame in flight; arbitrate among enabled requesters
// REQ     | tx_request high, waiting for the transmitter to report START
// SEND    | frame in progress, word frozen, waiting for STOP
// DONE    | one cycle: ack client, count frame, advance rr pointer
module uart_tx_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CLIENTS-1:0]                 cl_req,
    input  logic [NUM_CLIENTS*9-1:0]               cl_data,
    output logic [NUM_CLIENTS-1:0]                 cl_ack,
    input  logic [NUM_CLIENTS-1:0]                 cfg_enable,
    output logic                                   tx_request,
    output logic [8:0]                             tx_data,
    input  logic [3:0]                             tx_state,
    output logic                                   busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]         grant_id,
    output logic [15:0]                            frames_sent,
    output logic                                   wdog_err
);
    import uart_pkg::*;

    localparam int IW = $clog2(NUM_CLIENTS);

    sched_state_t             state, state_next;
    logic [NUM_CLIENTS-1:0]   eligible;
    logic [NUM_CLIENTS-1:0]   grant_oh;
    logic [IW-1:0]            arb_idx;
    logic                     arb_any;
    logic [IW-1:0]            rr_ptr;
    logic [IW-1:0]            ptr_after;
    logic [UART_WORD_W-1:0]   sel_word;
    logic                     abort;

    assign eligible = cl_req & cfg_enable;
    assign busy     = (state != ST_IDLE);

    rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_rr_arbiter (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_oh[i]) begin
                sel_word = sel_word | cl_data[i*UART_WORD_W +: UART_WORD_W];
            end
        end
    end

    assign ptr_after = (grant_id == IW'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_TX_SCHED_WDOG_EN
    // Down-counter reloaded on every state change; terminal count at zero aborts the frame.
    localparam logic [15:0] WDOG_LOAD = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt;

    assign abort = ((state == ST_REQ) || (state == ST_SEND)) && (wdog_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= WDOG_LOAD;
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= abort;
            if (state_next != state) begin
                wdog_cnt <= WDOG_LOAD;
            end else if (busy && (wdog_cnt != 16'd0)) begin
                wdog_cnt <= wdog_cnt - 16'd1;
            end
        end
    end
`else
    assign abort    = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (arb_any) state_next = ST_REQ;
            ST_REQ: begin
                if (abort)                   state_next = ST_IDLE;
                else if (tx_state == START_S) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (abort)                   state_next = ST_IDLE;
                else if (tx_state == STOP_S)  state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_request  <= 1'b0;
            tx_data     <= '0;
            cl_ack      <= '0;
            grant_id    <= '0;
            frames_sent <= '0;
            rr_ptr      <= '0;
        end else begin
            cl_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        tx_data    <= sel_word;
                        grant_id   <= arb_idx;
                        tx_request <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        tx_request <= 1'b0;
                        rr_ptr     <= ptr_after;
                    end else if (tx_state == START_S) begin
                        tx_request <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        rr_ptr <= ptr_after;
                    end else if (tx_state == STOP_S) begin
                        cl_ack[grant_id] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    frames_sent <= frames_sent + 16'd1;
                    rr_ptr      <= ptr_after;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a behavioural transmitter and round-robin model.
// Watchdog scenario runs only when UART_TX_SCHED_WDOG_EN is defined.
module tb_uart_tx_scheduler;

    localparam int NC = 4;
    localparam int WD = 16;

    logic             clk;
    logic             reset;
    logic [NC-1:0]    cl_req;
    logic [NC*9-1:0]  cl_data;
    logic [NC-1:0]    cl_ack;
    logic [NC-1:0]    cfg_enable;
    logic             tx_request;
    logic [8:0]       tx_data;
    logic [3:0]       tx_state;
    logic             busy;
    logic [1:0]       grant_id;
    logic [15:0]      frames_sent;
    logic             wdog_err;

    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    int m_frames = 0;
    logic [8:0] words [NC];

    uart_tx_scheduler #(.NUM_CLIENTS(NC), .WDOG_CYCLES(WD)) dut (
        .clk         (clk),
        .reset       (reset),
        .cl_req      (cl_req),
        .cl_data     (cl_data),
        .cl_ack      (cl_ack),
        .cfg_enable  (cfg_enable),
        .tx_request  (tx_request),
        .tx_data     (tx_data),
        .tx_state    (tx_state),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent),
        .wdog_err    (wdog_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_data();
        for (int i = 0; i < NC; i++) cl_data[i*9 +: 9] = words[i];
    endtask

    // Spec rule: first eligible client at or after the pointer, wrapping upward.
    function automatic int model_pick(input logic [NC-1:0] elig);
        for (int i = 0; i < NC; i++) begin
            if (elig[(m_ptr + i) % NC]) return (m_ptr + i) % NC;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_request"}, tx_request, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_cl_ack"}, cl_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_frames_sent"}, frames_sent, 0);
        check({tag, "_wdog_err"}, wdog_err, 0);
    endtask

    // One complete frame driven by the transmitter model: codes 1..B then back to 0.
    // With chg set, the granted client changes its word, drops req and is disabled mid-frame.
    task automatic run_frame(input int exp_g, input bit chg, input logic [8:0] chg_val);
        logic [NC-1:0] elig;
        logic [NC-1:0] ea;
        logic [8:0]    w;
        int            g;
        int            lat;
        bit            got;
        elig = cl_req & cfg_enable;
        g    = model_pick(elig);
        w    = (g >= 0) ? words[g] : 9'h0;
        got  = 1'b0;
        lat  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (tx_request === 1'b1) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        check("grant_seen", 32'(got), 1);
        if (!got) return;
        check("grant_latency", lat, 0);
        check("grant_id", grant_id, g);
        if (exp_g >= 0) check("grant_order", grant_id, exp_g);
        check("tx_data_at_grant", tx_data, w);
        check("busy_in_req", busy, 1);
        for (int c = 1; c <= 11; c++) begin
            tx_state = 4'(c);
            if (chg && c == 4) begin
                words[g]      = chg_val;
                cl_req[g]     = 1'b0;
                cfg_enable[g] = 1'b0;
                push_data();
            end
            @(negedge clk);
            ea = '0;
            if (c == 11) ea[g] = 1'b1;
            check("tx_data_hold", tx_data, w);
            check("cl_ack_pulse", cl_ack, ea);
            check("tx_request_low", tx_request, 0);
            check("wdog_quiet", wdog_err, 0);
        end
        m_frames++;
        m_ptr = (g + 1) % NC;
        tx_state = 4'h0;
        @(negedge clk);
        check("cl_ack_one_cycle", cl_ack, 0);
        check("frames_sent", frames_sent, 32'(m_frames & 16'hFFFF));
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int g;
        int k;
        bit seen;
        reset      = 1'b0;
        cl_req     = '0;
        cfg_enable = '1;
        tx_state   = 4'h0;
        for (int i = 0; i < NC; i++) words[i] = 9'(16 * i + 3);
        push_data();
        @(negedge clk);
        check_reset_outputs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // All four clients requesting continuously: strict 0,1,2,3
        cl_req = 4'b1111;
        for (int f = 0; f < NC; f++) run_frame(f, 1'b0, 9'h0);

        // Client 2 masked: 0,1,3,0
        cfg_enable = 4'b1011;
        run_frame(0, 1'b0, 9'h0);
        run_frame(1, 1'b0, 9'h0);
        run_frame(3, 1'b0, 9'h0);
        run_frame(0, 1'b0, 9'h0);
        cfg_enable = 4'b1111;

        // Single client 0 with word 155
        cl_req   = 4'b0001;
        words[0] = 9'h155;
        push_data();
        run_frame(0, 1'b0, 9'h0);

        // Client 1 changes data, drops req and is disabled during SEND; frame and ack still complete
        cl_req   = 4'b0010;
        words[1] = 9'h0AA;
        push_data();
        run_frame(1, 1'b1, 9'h1FF);
        cfg_enable = 4'b1111;

        // Reset mid-SEND: pointer sits at 2, after reset the next grant must be 0
        cl_req = 4'b0100;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (tx_request === 1'b1) begin seen = 1'b1; break; end
        end
        check("rst_pre_grant_seen", 32'(seen), 1);
        check("rst_pre_grant_id", grant_id, 2);
        tx_state = 4'h1;
        @(negedge clk);
        tx_state = 4'h3;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_send_reset");
        tx_state = 4'h0;
        cl_req   = '0;
        @(negedge clk);
        reset = 1'b1;
        m_ptr    = 0;
        m_frames = 0;
        @(negedge clk);
        check("post_reset_no_ack", cl_ack, 0);
        check("post_reset_no_req", tx_request, 0);
        cl_req = 4'b1111;
        run_frame(0, 1'b0, 9'h0);

        // Randomized traffic against the model
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NC; i++) words[i] = 9'($urandom);
            push_data();
            cfg_enable = NC'($urandom_range(1, 15));
            cl_req     = NC'($urandom_range(0, 15));
            if ((cl_req & cfg_enable) == '0) begin
                repeat (3) begin
                    @(negedge clk);
                    check("no_eligible_no_grant", tx_request, 0);
                    check("no_eligible_idle", busy, 0);
                end
                cl_req = cfg_enable;
            end
            run_frame(-1, 1'b0, 9'h0);
        end

`ifdef UART_TX_SCHED_WDOG_EN
        // Transmitter stuck at IDLE_S: watchdog aborts 16 cycles after REQ entry
        cfg_enable = 4'b1111;
        cl_req     = 4'b1111;
        tx_state   = 4'h0;
        g = model_pick(cl_req & cfg_enable);
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (tx_request === 1'b1) begin seen = 1'b1; break; end
        end
        check("wdog_grant_seen", 32'(seen), 1);
        check("wdog_grant_id", grant_id, g);
        k = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            check("wdog_no_ack", cl_ack, 0);
            if (wdog_err === 1'b1) begin k = j; break; end
        end
        check("wdog_delay", k, WD);
        check("wdog_tx_request", tx_request, 0);
        m_ptr = (g + 1) % NC;
        @(negedge clk);
        check("wdog_one_cycle", wdog_err, 0);
        check("wdog_frames", frames_sent, 32'(m_frames & 16'hFFFF));
        run_frame(-1, 1'b0, 9'h0);
`else
        check("wdog_tied_low", wdog_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
